// File: rtl/req_priority_encoder_if.sv
// Handshake and status bundle for req_priority_encoder.
// The master side (request source and code consumer) drives req_in, ovf_clr
// and out_ready. The slave side (the encoder) returns the code, the pending
// vector and the overflow flag.
interface req_priority_encoder_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N);

  logic [N-1:0]  req_in;
  logic          ovf_clr;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_code;
  logic [N-1:0]  pending;
  logic          ovf;

  modport master (
    output req_in, ovf_clr, out_ready,
    input  out_valid, out_code, pending, ovf
  );

  modport slave (
    input  req_in, ovf_clr, out_ready,
    output out_valid, out_code, pending, ovf
  );
endinterface

// File: rtl/req_priority_encoder.sv
// req_priority_encoder: latches up to N request lines into a pending register
// and delivers the index of the selected pending request over a valid/ready
// handshake. A served request is cleared on acceptance unless it is re-raised
// in the same cycle, in which case it stays pending.
// Default build: fixed priority, bit 0 highest.
// Optional macro ROUND_ROBIN_EN: rotating priority starting at rr_ptr, which
// moves to one past the accepted code on every handshake.
module req_priority_encoder #(
  parameter int N = 8
) (
  input logic                  clk,
  input logic                  rst,
  req_priority_encoder_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  pending_q;
  logic [N-1:0]  pending_next;
  logic          out_valid_q;
  logic          out_valid_next;
  logic [CW-1:0] out_code_q;
  logic [CW-1:0] out_code_next;
  logic          ovf_q;
  logic          ovf_next;

  logic          handshake;
  logic [N-1:0]  serve_mask;
  logic [N-1:0]  sel_vec;
  logic          sel_any;
  logic [CW-1:0] sel_idx;
  logic          sel_found;

  // Decode the code register into a one-hot mask of the request being served.
  function automatic logic [N-1:0] code_onehot(input logic [CW-1:0] code);
    logic [N-1:0] mask;
    mask = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      mask[i] = (code == CW'(i)) ? 1'b1 : 1'b0;
    end
    return mask;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] rr_ptr_next;

  // Rotating scan: first set bit of sel_vec at or after rr_ptr, wrapping at N.
  always_comb begin
    sel_idx   = {CW{1'b0}};
    sel_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel_idx   = (!sel_found && sel_vec[(int'(rr_ptr) + i) % N])
                  ? CW'((int'(rr_ptr) + i) % N) : sel_idx;
      sel_found = sel_found | sel_vec[(int'(rr_ptr) + i) % N];
    end
  end

  // Pointer moves one past the accepted code, wrapping from N-1 to 0.
  always_comb begin
    if (!handshake) begin
      rr_ptr_next = rr_ptr;
    end else if (out_code_q == CW'(N - 1)) begin
      rr_ptr_next = {CW{1'b0}};
    end else begin
      rr_ptr_next = out_code_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= {CW{1'b0}};
    end else begin
      rr_ptr <= rr_ptr_next;
    end
  end
`else
  // Fixed scan: lowest set bit of sel_vec wins.
  always_comb begin
    sel_idx   = {CW{1'b0}};
    sel_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      sel_idx   = sel_vec[i] ? CW'(i) : sel_idx;
      sel_found = sel_found | sel_vec[i];
    end
  end
`endif

  assign handshake  = out_valid_q & bus.out_ready;
  assign serve_mask = handshake ? code_onehot(out_code_q) : {N{1'b0}};
  // In IDLE serve_mask is zero, so this is pending_q there; req_in never enters.
  assign sel_vec    = pending_q & ~serve_mask;
  assign sel_any    = |sel_vec;

  // Pending/overflow next values: a re-raised served bit stays set, and a new
  // overflow beats a simultaneous clear.
  always_comb begin
    pending_next = sel_vec | bus.req_in;
    if ((bus.req_in & sel_vec) != {N{1'b0}}) begin
      ovf_next = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf_q;
    end
  end

  // Handshake FSM: next state, next valid and next code.
  always_comb begin
    state_next     = state;
    out_valid_next = out_valid_q;
    out_code_next  = out_code_q;
    case (state)
      IDLE: begin
        if (sel_any) begin
          out_code_next  = sel_idx;
          out_valid_next = 1'b1;
          state_next     = HOLD;
        end else begin
          out_valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (handshake && sel_any) begin
          out_code_next = sel_idx;
        end else if (handshake) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end else begin
          out_valid_next = 1'b1;
        end
      end
      default: begin
        out_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  // State, output and pending registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending_q   <= {N{1'b0}};
      out_valid_q <= 1'b0;
      out_code_q  <= {CW{1'b0}};
      ovf_q       <= 1'b0;
    end else begin
      state       <= state_next;
      pending_q   <= pending_next;
      out_valid_q <= out_valid_next;
      out_code_q  <= out_code_next;
      ovf_q       <= ovf_next;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.pending   = pending_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_req_priority_encoder.sv
// Self-checking bench for req_priority_encoder: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_req_priority_encoder;
  localparam int N  = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  req_priority_encoder_if #(.N(N)) bus ();
  req_priority_encoder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [N-1:0]  m_pending;
  logic          m_valid;
  logic [CW-1:0] m_code;
  logic          m_ovf;
  int            m_rr;

  // First pending index in scan order starting at base.
  function automatic int pick(input logic [N-1:0] v, input int base);
    for (int k = 0; k < N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic rdy, input logic clr);
    logic          hs;
    logic [N-1:0]  rest;
    logic [N-1:0]  n_pending;
    logic          n_valid;
    logic [CW-1:0] n_code;
    logic          n_ovf;
    int            n_rr;
    int            base;
    rst           = r;
    bus.req_in    = rq;
    bus.out_ready = rdy;
    bus.ovf_clr   = clr;

    hs   = m_valid && rdy;
    rest = m_pending;
    if (hs) rest[m_code] = 1'b0;
`ifdef ROUND_ROBIN_EN
    base = m_rr;
`else
    base = 0;
`endif
    if (r) begin
      n_pending = '0; n_valid = 1'b0; n_code = '0; n_ovf = 1'b0; n_rr = 0;
    end else begin
      n_pending = rest | rq;
      n_ovf     = ((rq & rest) != 0) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      n_rr      = hs ? (m_code + 1) % N : m_rr;
      n_valid   = m_valid;
      n_code    = m_code;
      if (!m_valid || hs) begin
        if (rest != 0) begin
          n_valid = 1'b1;
          n_code  = CW'(pick(rest, base));
        end else begin
          n_valid = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    m_pending = n_pending; m_valid = n_valid; m_code = n_code; m_ovf = n_ovf; m_rr = n_rr;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_code",  32'(bus.out_code),  32'(m_code));
    check("pending",   32'(bus.pending),   32'(m_pending));
    check("ovf",       32'(bus.ovf),       32'(m_ovf));
  endtask

  initial begin
    m_pending = '0; m_valid = 1'b0; m_code = '0; m_ovf = 1'b0; m_rr = 0;
    rst = 1'b1; bus.req_in = '0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;

    // Reset state.
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_pending", 32'(bus.pending), 32'd0);

    // Single request: code 2 two edges later, then empty.
    step(1'b0, 8'b0000_0100, 1'b1, 1'b0);
    check("lat_pending", 32'(bus.pending), 32'h04);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_code", 32'(bus.out_code), 32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_pending", 32'(bus.pending), 32'd0);

    // Three requests with stalled consumer, then back-to-back delivery.
    step(1'b0, 8'b1001_0010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("stall_code", 32'(bus.out_code), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("b2b_idle", 32'(bus.out_valid), 32'd0);

    // Served bit re-raised during its handshake stays pending, no overflow.
    step(1'b0, 8'b0010_0000, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'b0010_0000, 1'b1, 1'b0);
    check("setwins_pending5", 32'(bus.pending[5]), 32'd1);
    check("setwins_ovf", 32'(bus.ovf), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow on a re-raised held bit, then clear.
    step(1'b0, 8'b0000_1000, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'b0000_1000, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.ovf), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(bus.ovf), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-HOLD with everything pending; req_in during reset is dropped.
    step(1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_pending", 32'(bus.pending), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Two requests held continuously with a ready consumer.
    for (int i = 0; i < 10; i++) step(1'b0, 8'b1000_0001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/req_priority_encoder.md
Name: req_priority_encoder

Overview:
- Sequential counterpart of the team's 3-to-8 one-hot decoders: collects up to 8 request lines and returns the index of the highest-priority pending request as a 3-bit code.
- Used as the exception/interrupt cause encoder feeding the MIPS control path.
- Requests are latched into a pending register. Codes are delivered over a valid/ready handshake, and a served request is cleared on acceptance.

Parameters:
- N, 8, number of request lines (legal range 2..32).
- CW, $clog2(N) (3 at default), width of the output code; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N  request pulses or levels; each set bit is OR-ed into pending every cycle.
- ovf_clr  input  1  synchronous clear of the ovf flag.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code when out_valid & out_ready (the handshake).
- out_code  output  CW  index of the selected request.
- pending  output  N  current pending register, pending_q.
- ovf  output  1  sticky flag: a request arrived while its bit was already pending.

Behaviour:
- Reset (rst=1 at an edge) gives pending_q=0, out_valid=0, out_code=0, ovf=0, state=IDLE, rr_ptr=0. This applies mid-handshake too: any in-flight code is dropped without completing, and req_in sampled in the reset cycle is discarded.
- The pending update each cycle is pending_q <= (pending_q & ~serve_mask) | req_in.
  - serve_mask is the one-hot of out_code during a handshake cycle, otherwise 0.
  - If req_in sets the same bit that is being served in that cycle, set wins and the bit stays pending.
- Fixed priority: bit 0 is highest and bit N-1 is lowest. The selection is a combinational scan of the masked vector sel_vec.
  - In IDLE, sel_vec = pending_q.
  - On a handshake, sel_vec = pending_q & ~serve_mask.
  - req_in from the current cycle is never included in the selection.
- State machine:
  - IDLE: out_valid=0. If pending_q!=0, register out_code=encode(sel_vec) and out_valid=1, then go to HOLD. Otherwise stay in IDLE.
  - HOLD: out_valid=1, and out_code is held stable while out_ready=0.
  - HOLD on a handshake with sel_vec!=0: load the next code in the same edge and stay in HOLD. This gives back-to-back delivery with one code per cycle.
  - HOLD on a handshake with sel_vec==0: out_valid<=0, go to IDLE. out_code keeps its last value.
- Latency: req_in asserted at edge t, with the block idle and empty, gives pending_q set at t+1 and out_valid=1 with the code at t+2.
- Priority is not pre-emptive. A higher-priority request arriving while in HOLD does not change the presented out_code; it is selected at the next handshake.
- ovf is set at an edge when (req_in & pending_q & ~serve_mask)!=0. It is cleared only by ovf_clr or rst. If ovf_clr and a new overflow occur in the same cycle, set wins.
- A bit whose pending_q is 1 is never cleared except by its own handshake or by rst.
- out_valid is never deasserted without a handshake, except by rst.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined: rotating priority.
  - rr_ptr (CW bits, reset 0) names the highest-priority index. The scan order is rr_ptr, rr_ptr+1, ... with wrap modulo N.
  - On each handshake, rr_ptr <= (out_code+1) mod N. At out_code=N-1 this wraps to 0.
  - All other rules (set-wins, latency, ovf) are unchanged.
- Undefined: fixed priority as above. rr_ptr logic is not present.

Test Plan:
- Reset, then req_in=8'b0000_0100 for one cycle with out_ready=1 → out_valid=1 with out_code=3'd2 two edges later. The next cycle gives out_valid=0 and pending=0.
- req_in=8'b1001_0010 for one cycle, with out_ready=0 for 3 cycles and then 1 → out_code=1 held for 3 cycles, then 4 and 7 on consecutive cycles, then out_valid=0.
- In HOLD with out_code=5, pulse req_in=8'b0010_0000 during the handshake cycle → pending[5] stays 1, and out_code=5 is re-presented on the next cycle. ovf stays 0.
- In HOLD with out_code=3 and out_ready=0, pulse req_in bit 3 → ovf=1 at the next edge. Then pulse ovf_clr → ovf=0 at the following edge.
- Assert rst mid-HOLD with pending=8'hFF → next edge gives out_valid=0, pending=0, and ovf=0. req_in sampled during the reset cycle is ignored.
- ROUND_ROBIN_EN: hold req_in=8'b1000_0001 continuously with out_ready=1 → out_code sequence 0,7,0,7…. Without the macro the sequence is 0,0,0….
